// File: rtl/nco_sweep_ctrl.sv
// rtl/nco_sweep_ctrl.sv - linear FTW sweep sequencer feeding the NCO tuning word
//
// Purpose: steps a registered frequency tuning word from a start value to a stop
// value in fixed hops, holding each value for a programmable number of cycles.
// It runs either one-shot or repeating.
//
// Ports:
//   clk_top, rst_top   clock and synchronous active-high reset
//   cfg_start_ftw      first tuning word of the sweep
//   cfg_stop_ftw       last tuning word; the sweep runs upward when stop >= start
//   cfg_step           hop magnitude; zero is rejected at start
//   cfg_dwell          cycles each value is held; zero is treated as one
//   cfg_repeat         restart from the start value after reaching stop
//   start, abort       sweep request (honoured in IDLE) and unconditional stop
//   ftw_out, ftw_upd   tuning word, plus a pulse in the first cycle of each new value
//   busy, done, cfg_err  sweep active, one-shot completion pulse, rejected-start pulse
module nco_sweep_ctrl #(
    parameter int FTW_W   = 32,
    parameter int DWELL_W = 16
) (
    input  logic               clk_top,
    input  logic               rst_top,
    input  logic [FTW_W-1:0]   cfg_start_ftw,
    input  logic [FTW_W-1:0]   cfg_stop_ftw,
    input  logic [FTW_W-1:0]   cfg_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               cfg_repeat,
    input  logic               start,
    input  logic               abort,
    output logic [FTW_W-1:0]   ftw_out,
    output logic               ftw_upd,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
);

    typedef enum logic {S_IDLE, S_DWELL} state_t;

    localparam logic [DWELL_W-1:0] DW_ONE = DWELL_W'(1);

    state_t             state_q, state_d;
    logic [FTW_W-1:0]   ftw_q, ftw_d;
    logic               upd_q, upd_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;

    // Shadow copies of the configuration, frozen for the whole sweep.
    logic [FTW_W-1:0]   sh_start_q, sh_start_d;
    logic [FTW_W-1:0]   sh_stop_q, sh_stop_d;
    logic [FTW_W-1:0]   sh_step_q, sh_step_d;
    logic [DWELL_W-1:0] sh_dwell_q, sh_dwell_d;
    logic               sh_rpt_q, sh_rpt_d;
    logic               sh_up_q, sh_up_d;

    logic [FTW_W:0]     sum_w, diff_w;
    logic [FTW_W-1:0]   hop_w;
    logic [DWELL_W-1:0] dwell_eff_w;

    // The extra top bit catches overflow (up) or borrow (down), so a hop that
    // would leave the FTW range clamps to stop instead of wrapping.
    always_comb begin
        sum_w  = {1'b0, ftw_q} + {1'b0, sh_step_q};
        diff_w = {1'b0, ftw_q} - {1'b0, sh_step_q};
        if (sh_up_q) begin
            hop_w = (sum_w[FTW_W] || (sum_w[FTW_W-1:0] > sh_stop_q)) ? sh_stop_q : sum_w[FTW_W-1:0];
        end else begin
            hop_w = (diff_w[FTW_W] || (diff_w[FTW_W-1:0] < sh_stop_q)) ? sh_stop_q : diff_w[FTW_W-1:0];
        end
        dwell_eff_w = (cfg_dwell == '0) ? DW_ONE : cfg_dwell;
    end

    always_comb begin
        state_d    = state_q;
        ftw_d      = ftw_q;
        upd_d      = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        cnt_d      = cnt_q;
        sh_start_d = sh_start_q;
        sh_stop_d  = sh_stop_q;
        sh_step_d  = sh_step_q;
        sh_dwell_d = sh_dwell_q;
        sh_rpt_d   = sh_rpt_q;
        sh_up_d    = sh_up_q;

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (cfg_step == '0) begin
                            err_d = 1'b1;
                        end else begin
                            sh_start_d = cfg_start_ftw;
                            sh_stop_d  = cfg_stop_ftw;
                            sh_step_d  = cfg_step;
                            sh_dwell_d = dwell_eff_w;
                            sh_rpt_d   = cfg_repeat;
                            sh_up_d    = (cfg_stop_ftw >= cfg_start_ftw);
                            ftw_d      = cfg_start_ftw;
                            upd_d      = 1'b1;
                            cnt_d      = dwell_eff_w - DW_ONE;
                            state_d    = S_DWELL;
                        end
                    end
                end
                S_DWELL: begin
                    // cnt counts the remaining hold cycles after the current one.
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - DW_ONE;
                    end else if (ftw_q != sh_stop_q) begin
                        ftw_d = hop_w;
                        upd_d = 1'b1;
                        cnt_d = sh_dwell_q - DW_ONE;
                    end else if (sh_rpt_q) begin
                        ftw_d = sh_start_q;
                        upd_d = 1'b1;
                        cnt_d = sh_dwell_q - DW_ONE;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_top) begin
        if (rst_top) begin
            state_q    <= S_IDLE;
            ftw_q      <= '0;
            upd_q      <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            sh_start_q <= '0;
            sh_stop_q  <= '0;
            sh_step_q  <= '0;
            sh_dwell_q <= '0;
            sh_rpt_q   <= 1'b0;
            sh_up_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ftw_q      <= ftw_d;
            upd_q      <= upd_d;
            done_q     <= done_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            sh_start_q <= sh_start_d;
            sh_stop_q  <= sh_stop_d;
            sh_step_q  <= sh_step_d;
            sh_dwell_q <= sh_dwell_d;
            sh_rpt_q   <= sh_rpt_d;
            sh_up_q    <= sh_up_d;
        end
    end

    assign ftw_out = ftw_q;
    assign ftw_upd = upd_q;
    assign busy    = (state_q == S_DWELL);
    assign done    = done_q;
    assign cfg_err = err_q;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// tb/tb_nco_sweep_ctrl.sv - directed scoreboard bench for nco_sweep_ctrl
module tb_nco_sweep_ctrl;

    logic        clk_top = 1'b0;
    logic        rst_top;
    logic [31:0] cfg_start_ftw, cfg_stop_ftw, cfg_step;
    logic [15:0] cfg_dwell;
    logic        cfg_repeat, start, abort;
    logic [31:0] ftw_out;
    logic        ftw_upd, busy, done, cfg_err;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    nco_sweep_ctrl #(.FTW_W(32), .DWELL_W(16)) dut (
        .clk_top(clk_top), .rst_top(rst_top),
        .cfg_start_ftw(cfg_start_ftw), .cfg_stop_ftw(cfg_stop_ftw),
        .cfg_step(cfg_step), .cfg_dwell(cfg_dwell), .cfg_repeat(cfg_repeat),
        .start(start), .abort(abort),
        .ftw_out(ftw_out), .ftw_upd(ftw_upd), .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk_top = ~clk_top;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step_clk();
        @(posedge clk_top);
        #1;
    endtask

    // Pops the next scoreboard value and checks it is presented with an update
    // pulse and then held unchanged for d cycles; optionally fires a junk start
    // and junk configuration while the sweep is busy.
    task automatic check_hold(input int d, input bit junk);
        logic [31:0] want;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        want = exp_q.pop_front();
        chk("upd_pulse", 32'(ftw_upd), 32'd1);
        chk("ftw_value", ftw_out, want);
        chk("busy_hold", 32'(busy), 32'd1);
        chk("no_done", 32'(done), 32'd0);
        if (junk) begin
            start = 1'b1;
            cfg_start_ftw = 32'hDEAD_BEEF;
            cfg_stop_ftw  = 32'h0000_0001;
            cfg_step      = 32'h0;
            cfg_dwell     = 16'd7;
        end
        for (int k = 1; k < d; k++) begin
            step_clk();
            start = 1'b0;
            chk("upd_low", 32'(ftw_upd), 32'd0);
            chk("ftw_held", ftw_out, want);
            chk("busy_in_hold", 32'(busy), 32'd1);
        end
        step_clk();
        start = 1'b0;
    endtask

    task automatic launch(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                          input logic [15:0] dw, input logic rpt);
        step_clk();
        cfg_start_ftw = s;
        cfg_stop_ftw  = e;
        cfg_step      = st;
        cfg_dwell     = dw;
        cfg_repeat    = rpt;
        start         = 1'b1;
        step_clk();
        start         = 1'b0;
    endtask

    // One-shot sweep: the expected FTW sequence comes from a 64-bit model.
    task automatic run_sweep(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                             input logic [15:0] dw, input bit junk);
        longint cur, nxt, e64, st64;
        int d;
        cur  = s;
        e64  = e;
        st64 = st;
        exp_q.push_back(s);
        for (int g = 0; g < 64 && cur != e64; g++) begin
            if (e >= s) begin
                nxt = cur + st64;
                if (nxt > e64) nxt = e64;
            end else begin
                nxt = cur - st64;
                if (nxt < e64) nxt = e64;
            end
            cur = nxt;
            exp_q.push_back(32'(cur));
        end
        d = (dw == 0) ? 1 : int'(dw);
        launch(s, e, st, dw, 1'b0);
        for (int g = 0; g < 64 && exp_q.size() > 0; g++) begin
            check_hold(d, junk && (g == 0));
        end
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_end", 32'(busy), 32'd0);
        chk("upd_end", 32'(ftw_upd), 32'd0);
        chk("ftw_final", ftw_out, e);
        step_clk();
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("ftw_persists", ftw_out, e);
    endtask

    initial begin
        rst_top = 1'b1;
        cfg_start_ftw = '0; cfg_stop_ftw = '0; cfg_step = '0;
        cfg_dwell = '0; cfg_repeat = 1'b0; start = 1'b0; abort = 1'b0;
        step_clk();
        step_clk();
        rst_top = 1'b0;
        chk("rst_ftw", ftw_out, 32'd0);
        chk("rst_upd", 32'(ftw_upd), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(cfg_err), 32'd0);

        run_sweep(32'd100, 32'd130, 32'd10, 16'd3, 1'b0);
        run_sweep(32'd0, 32'd25, 32'd10, 16'd0, 1'b0);
        run_sweep(32'h10, 32'h0, 32'h20, 16'd2, 1'b0);
        run_sweep(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 16'd1, 1'b0);
        run_sweep(32'd55, 32'd55, 32'd4, 16'd2, 1'b0);

        // Repeat mode, then abort in the middle of a hold.
        exp_q.push_back(32'd268435450);
        exp_q.push_back(32'd268435460);
        exp_q.push_back(32'd268435470);
        exp_q.push_back(32'd268435450);
        launch(32'd268435450, 32'd268435470, 32'd10, 16'd2, 1'b1);
        for (int g = 0; g < 4; g++) check_hold(2, 1'b0);
        chk("rpt_upd", 32'(ftw_upd), 32'd1);
        chk("rpt_ftw", ftw_out, 32'd268435460);
        abort = 1'b1;
        step_clk();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_upd", 32'(ftw_upd), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_ftw", ftw_out, 32'd268435460);
        for (int k = 0; k < 4; k++) begin
            step_clk();
            chk("post_abort_done", 32'(done), 32'd0);
            chk("post_abort_ftw", ftw_out, 32'd268435460);
        end

        // Zero step is rejected and leaves ftw_out alone.
        launch(32'd7, 32'd9, 32'd0, 16'd1, 1'b0);
        chk("err_pulse", 32'(cfg_err), 32'd1);
        chk("err_busy", 32'(busy), 32'd0);
        chk("err_ftw", ftw_out, 32'd268435460);
        step_clk();
        chk("err_one_cycle", 32'(cfg_err), 32'd0);
        chk("err_stays_idle", 32'(busy), 32'd0);

        // Start and configuration changes while busy are ignored.
        run_sweep(32'd100, 32'd130, 32'd10, 16'd3, 1'b1);

        // Reset in mid-sweep, with start asserted at the same time.
        exp_q.push_back(32'd100);
        launch(32'd100, 32'd130, 32'd10, 16'd3, 1'b0);
        check_hold(3, 1'b0);
        rst_top = 1'b1;
        start = 1'b1;
        step_clk();
        rst_top = 1'b0;
        start = 1'b0;
        chk("mid_rst_ftw", ftw_out, 32'd0);
        chk("mid_rst_upd", 32'(ftw_upd), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_err", 32'(cfg_err), 32'd0);
        step_clk();
        chk("after_rst_busy", 32'(busy), 32'd0);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
